// File: rtl/cmd_issue_sched.sv
// Credit-gated round-robin issue scheduler feeding one registered command slot.
// Optional sticky protocol check on responses: CMD_ISSUE_SCHED_ERR_CHECK_EN.
module cmd_issue_sched #(
    parameter int NUM_CLUSTERS    = 4,
    parameter int CMD_W           = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int GLOBAL_CREDITS  = 8,
    parameter int CID_W           = $clog2(NUM_CLUSTERS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_CLUSTERS-1:0]     req_valid_i,
    output logic [NUM_CLUSTERS-1:0]     req_ready_o,
    input  logic [NUM_CLUSTERS*CMD_W-1:0] req_cmd_i,
    output logic                        intf_valid_o,
    input  logic                        intf_ready_i,
    output logic [CMD_W-1:0]            intf_cmd_o,
    output logic [CID_W-1:0]            intf_src_o,
    input  logic                        resp_valid_i,
    input  logic [CID_W-1:0]            resp_src_i,
    output logic [NUM_CLUSTERS*$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                        idle_o,
    output logic                        err_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int GCNT_W = $clog2(GLOBAL_CREDITS + 1);

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    state_t                               state_q;
    state_t                               state_d;
    logic [CID_W-1:0]                     ptr_q;
    logic [CID_W-1:0]                     ptr_d;
    logic [NUM_CLUSTERS-1:0][CNT_W-1:0]   cnt_q;
    logic [NUM_CLUSTERS-1:0][CNT_W-1:0]   cnt_d;
    logic [GCNT_W-1:0]                    gcnt_q;
    logic [GCNT_W-1:0]                    gcnt_d;
    logic [CMD_W-1:0]                     cmd_q;
    logic [CID_W-1:0]                     src_q;
    logic                                 idle_q;

    logic [NUM_CLUSTERS-1:0]              elig;
    logic [NUM_CLUSTERS-1:0]              inc;
    logic [NUM_CLUSTERS-1:0]              dec;
    logic                                 can_issue;
    logic                                 accept;
    logic                                 grant;
    logic [CID_W-1:0]                     gidx;
    logic [CMD_W-1:0]                     gcmd;

    // Slot can take a new command when empty or when it is draining this cycle
    always_comb begin
        accept    = (state_q == ST_FULL) && intf_ready_i;
        can_issue = !rst_i && ((state_q == ST_EMPTY) || intf_ready_i);
    end

    // Eligibility uses registered counts only, so same-cycle responses do not help
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            elig[i] = req_valid_i[i]
                   && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING))
                   && (gcnt_q < GCNT_W'(GLOBAL_CREDITS));
        end
    end

    // Round-robin search starting at ptr, wrapping upward
    always_comb begin
        int idx;
        idx   = 0;
        grant = 1'b0;
        gidx  = '0;
        for (int off = 0; off < NUM_CLUSTERS; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_CLUSTERS) begin
                idx = idx - NUM_CLUSTERS;
            end
            for (int i = 0; i < NUM_CLUSTERS; i++) begin
                if (!grant && can_issue && (i == idx) && elig[i]) begin
                    grant = 1'b1;
                    gidx  = CID_W'(i);
                end
            end
        end
    end

    // One-hot ready for the winner and payload select
    always_comb begin
        req_ready_o = '0;
        gcmd        = '0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            if (grant && (gidx == CID_W'(i))) begin
                req_ready_o[i] = 1'b1;
                gcmd           = req_cmd_i[i*CMD_W +: CMD_W];
            end
        end
    end

    // Per-cluster credit bookkeeping; underflow and bad ids are ignored
    always_comb begin
        inc   = '0;
        dec   = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            inc[i] = grant && (gidx == CID_W'(i));
            dec[i] = resp_valid_i
                  && (resp_src_i == CID_W'(i))
                  && (cnt_q[i] != '0);
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Global credit count follows the same net-zero rule
    always_comb begin
        gcnt_d = gcnt_q;
        if ((|inc) && !(|dec)) begin
            gcnt_d = gcnt_q + GCNT_W'(1);
        end else if ((|dec) && !(|inc) && (gcnt_q != '0)) begin
            gcnt_d = gcnt_q - GCNT_W'(1);
        end
    end

    // Output stage next state and arbitration pointer advance
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (grant) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (grant) begin
                    state_d = ST_FULL;
                end else if (accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (grant) begin
            if (gidx == CID_W'(NUM_CLUSTERS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx + CID_W'(1);
            end
        end
    end

    // State, pointer and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            idle_q  <= (state_d == ST_EMPTY) && !(|cnt_d);
        end
    end

    // Command slot loads only on grant so it holds during back-pressure
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q <= '0;
            src_q <= '0;
        end else if (grant) begin
            cmd_q <= gcmd;
            src_q <= gidx;
        end
    end

    assign intf_valid_o  = (state_q == ST_FULL);
    assign intf_cmd_o    = cmd_q;
    assign intf_src_o    = src_q;
    assign outstanding_o = cnt_q;
    assign idle_o        = idle_q;

`ifdef CMD_ISSUE_SCHED_ERR_CHECK_EN
    logic err_q;
    logic bad_resp;

    // A response that retires nothing is an underflow or an unknown id
    always_comb begin
        bad_resp = resp_valid_i && !(|dec);
    end

    // Sticky error flag cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (bad_resp) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_issue_sched.sv
// Self-checking bench for cmd_issue_sched: directed plan plus random traffic
// compared every cycle against a credit/round-robin model.
module tb_cmd_issue_sched;

    localparam int N  = 4;
    localparam int CW = 64;
    localparam int MO = 4;
    localparam int GC = 8;
    localparam int IW = 2;
    localparam int OW = 3;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N*CW-1:0]   req_cmd_i = '0;
    logic              intf_valid_o;
    logic              intf_ready_i = 1'b0;
    logic [CW-1:0]     intf_cmd_o;
    logic [IW-1:0]     intf_src_o;
    logic              resp_valid_i = 1'b0;
    logic [IW-1:0]     resp_src_i = '0;
    logic [N*OW-1:0]   outstanding_o;
    logic              idle_o;
    logic              err_o;

    always #5 clk = ~clk;

    cmd_issue_sched #(
        .NUM_CLUSTERS(N),
        .CMD_W(CW),
        .MAX_OUTSTANDING(MO),
        .GLOBAL_CREDITS(GC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_cmd_i(req_cmd_i),
        .intf_valid_o(intf_valid_o),
        .intf_ready_i(intf_ready_i),
        .intf_cmd_o(intf_cmd_o),
        .intf_src_o(intf_src_o),
        .resp_valid_i(resp_valid_i),
        .resp_src_i(resp_src_i),
        .outstanding_o(outstanding_o),
        .idle_o(idle_o),
        .err_o(err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          m_cnt[N];
    int          m_ptr;
    bit          m_full;
    logic [CW-1:0] m_cmd;
    int          m_src;
    bit          m_err;
    logic [CW-1:0] cmds[N];

`ifdef CMD_ISSUE_SCHED_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int msum();
        int s = 0;
        for (int i = 0; i < N; i++) s += m_cnt[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr  = 0;
        m_full = 0;
        m_cmd  = '0;
        m_src  = 0;
        m_err  = 0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic [N-1:0] v, input logic rdy,
                        input logic rv, input logic [IW-1:0] rs,
                        output logic [N-1:0] dr);
        logic [N-1:0] exp_rdy;
        int g;
        int k;
        bit ok;
        req_valid_i  = v;
        intf_ready_i = rdy;
        resp_valid_i = rv;
        resp_src_i   = rs;
        for (int i = 0; i < N; i++) begin
            cmds[i] = {$urandom, $urandom};
            req_cmd_i[i*CW +: CW] = cmds[i];
        end
        #4;
        g = -1;
        if ((!m_full || rdy) && msum() < GC) begin
            for (int off = 0; off < N; off++) begin
                k = (m_ptr + off) % N;
                if (g < 0 && v[k] && m_cnt[k] < MO) g = k;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy = N'(1) << g;
        dr = req_ready_o;
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        chk("intf_valid", 64'(intf_valid_o), 64'(m_full));
        if (m_full) begin
            chk("intf_cmd", intf_cmd_o, m_cmd);
            chk("intf_src", 64'(intf_src_o), 64'(m_src));
        end
        for (int i = 0; i < N; i++)
            chk("outstanding", 64'(outstanding_o[i*OW +: OW]), 64'(m_cnt[i]));
        chk("idle", 64'(idle_o), 64'(!m_full && msum() == 0));
        chk("err", 64'(err_o), 64'(m_err));
        ok = rv && (int'(rs) < N) && m_cnt[rs] > 0;
        if (ERR_EN && rv && !ok) m_err = 1;
        if (g >= 0) begin
            m_full = 1;
            m_cmd  = cmds[g];
            m_src  = g;
            m_ptr  = (g + 1) % N;
            m_cnt[g]++;
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        if (ok) m_cnt[rs]--;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req_valid_i  = '1;
        intf_ready_i = 1'b1;
        resp_valid_i = 1'b0;
        rst_i        = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_valid", 64'(intf_valid_o), 64'(0));
        chk("rst_cmd", intf_cmd_o, 64'(0));
        chk("rst_src", 64'(intf_src_o), 64'(0));
        chk("rst_out", 64'(outstanding_o), 64'(0));
        chk("rst_idle", 64'(idle_o), 64'(1));
        chk("rst_err", 64'(err_o), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_ready_hold", 64'(req_ready_o), 64'(0));
        rst_i = 1'b0;
    endtask

    task automatic drain();
        logic [N-1:0] dr;
        int s;
        for (int c = 0; c < 40 && msum() > 0; c++) begin
            s = 0;
            for (int i = N - 1; i >= 0; i--) if (m_cnt[i] > 0) s = i;
            step('0, 1'b1, 1'b1, IW'(s), dr);
        end
        step('0, 1'b1, 1'b0, '0, dr);
        chk("drained", 64'(outstanding_o), 64'(0));
    endtask

    initial begin
        logic [N-1:0] dr;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int n;
        int per[N];
        logic rv;
        logic [IW-1:0] rs;
        int s;

        model_reset();
        @(posedge clk);
        #1;

        // Round-robin order with immediate responses
        reset_dut();
        for (int t = 0; t < 5; t++) begin
            rv = m_full;
            rs = IW'(m_src);
            step('1, 1'b1, rv, rs, dr);
            chk("rr_order", 64'(dr), 64'(N'(1) << exp_seq[t]));
        end
        chk("src_after", 64'(intf_src_o), 64'(0));
        drain();

        // Single cluster runs out of per-cluster credits
        reset_dut();
        n = 0;
        for (int t = 0; t < 6; t++) begin
            step(4'b0100, 1'b1, 1'b0, '0, dr);
            n += int'(dr[2]);
        end
        chk("c2_grants", 64'(n), 64'(4));
        chk("c2_out", 64'(outstanding_o[2*OW +: OW]), 64'(4));
        step(4'b0100, 1'b1, 1'b1, 2'd2, dr);
        chk("c2_blocked", 64'(dr), 64'(0));
        step(4'b0100, 1'b1, 1'b0, '0, dr);
        chk("c2_regrant", 64'(dr), 64'(4'b0100));
        drain();

        // Global credit exhaustion
        reset_dut();
        n = 0;
        for (int i = 0; i < N; i++) per[i] = 0;
        for (int t = 0; t < 12; t++) begin
            step('1, 1'b1, 1'b0, '0, dr);
            n += $countones(dr);
            for (int i = 0; i < N; i++) per[i] += int'(dr[i]);
        end
        chk("g_total", 64'(n), 64'(8));
        for (int i = 0; i < N; i++) chk("g_per", 64'(per[i]), 64'(2));
        chk("g_idle", 64'(idle_o), 64'(0));
        drain();

        // Back-pressure holds the slot and the pointer
        reset_dut();
        step('1, 1'b1, 1'b0, '0, dr);
        chk("bp_first", 64'(dr), 64'(4'b0001));
        for (int t = 0; t < 5; t++) begin
            step('1, 1'b0, 1'b0, '0, dr);
            chk("bp_noready", 64'(dr), 64'(0));
            chk("bp_src", 64'(intf_src_o), 64'(0));
        end
        step('1, 1'b1, 1'b0, '0, dr);
        chk("bp_next", 64'(dr), 64'(4'b0010));
        drain();

        // Underflow response
        reset_dut();
        step('0, 1'b1, 1'b1, 2'd1, dr);
        chk("uf_out", 64'(outstanding_o), 64'(0));
        chk("uf_err", 64'(err_o), 64'(ERR_EN));
        step('0, 1'b1, 1'b0, '0, dr);

        // Same-cycle grant and response on cluster 3
        reset_dut();
        step(4'b1000, 1'b1, 1'b0, '0, dr);
        step(4'b1000, 1'b1, 1'b0, '0, dr);
        chk("nz_pre", 64'(outstanding_o[3*OW +: OW]), 64'(2));
        step(4'b1000, 1'b1, 1'b1, 2'd3, dr);
        chk("nz_grant", 64'(dr), 64'(4'b1000));
        chk("nz_post", 64'(outstanding_o[3*OW +: OW]), 64'(2));
        drain();

        // Random traffic with one mid-run reset
        reset_dut();
        for (int t = 0; t < 3000; t++) begin
            if (t == 1500) reset_dut();
            rv = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0 || msum() == 0) begin
                rs = IW'($urandom_range(0, N - 1));
            end else begin
                s = $urandom_range(0, N - 1);
                while (m_cnt[s] == 0) s = (s + 1) % N;
                rs = IW'(s);
            end
            step(N'($urandom), ($urandom_range(0, 3) != 0), rv, rs, dr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
